// File: rtl/i2c_slave_engine_if.sv
// i2c_slave_engine_if
// Bundles the pad-side and register-side signals of the I2C responder.
//   scl_i, sda_i      : synchronous-domain pad inputs
//   sda_o, sda_oen    : SDA drive value (always 0) and active-low output enable
//   rx_data, rx_valid,
//   rx_first          : written data byte, its strobe, and first-byte qualifier
//   tx_data, tx_rd    : read data byte and its request/consume strobe
//   busy, start_det,
//   stop_det          : bus status and condition strobes
// Modport slave is taken by the engine; modport master by whoever drives the
// pads and serves the register layer.
interface i2c_slave_engine_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic       sda_oen;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic [7:0] tx_data;
  logic       tx_rd;
  logic       busy;
  logic       start_det;
  logic       stop_det;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_o, sda_oen, rx_data, rx_valid, rx_first, tx_rd,
           busy, start_det, stop_det
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_o, sda_oen, rx_data, rx_valid, rx_first, tx_rd,
           busy, start_det, stop_det
  );
endinterface

// File: rtl/i2c_slave_engine.sv
// i2c_slave_engine
// Byte-level I2C target: detects START/STOP, matches a 7-bit address, ACKs,
// hands written bytes to the register layer and fetches read bytes from it.
// No clock stretching; SDA is open-drain emulated (sda_o=0, sda_oen drives).
// Ports:
//   clk    : system clock (>= 10x SCL)
//   rst_n  : asynchronous active-low reset
//   bus    : i2c_slave_engine_if.slave (pads, rx/tx byte handshake, status)
// Parameters:
//   ADDRESS     : 7-bit target address
//   SYNC_STAGES : synchroniser depth on SCL and SDA (>= 2)
// Optional feature macro I2C_SLAVE_GLITCH_FILTER_EN: adds a 3-sample majority
// filter after the synchronisers (rejects <= 1 clk pulses, +2 clk latency).
module i2c_slave_engine #(
  parameter logic [6:0] ADDRESS     = 7'h0F,
  parameter int         SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  i2c_slave_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // Synchronisers reset to 1 so an idle bus produces no events after reset.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
      sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl_s = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
                 (scl_hist[1] & scl_hist[2]);
  assign sda_s = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                 (sda_hist[1] & sda_hist[2]);
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  // START/STOP need SCL high in both samples, so they never coincide with an
  // SCL edge.
  logic scl_r, scl_f, start_ev, stop_ev;
  assign scl_r    =  scl_s & ~scl_d;
  assign scl_f    = ~scl_s &  scl_d;
  assign start_ev =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_ev  =  scl_s &  scl_d & ~sda_d &  sda_s;

  state_t     state, state_n;
  logic [2:0] bit_cnt, cnt_n;
  logic [7:0] shift_q, shift_n, rxd_q, rxd_n;
  logic       full_q, full_n, first_q, first_n, oen_q, oen_n;
  logic       rxv_q, rxv_n, rxf_q, rxf_n, busy_q, busy_n;
  logic       start_q, start_n, stop_q, stop_n, tx_rd_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      first_q <= 1'b0;
      oen_q   <= 1'b1;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      rxf_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shift_q <= shift_n;
      full_q  <= full_n;
      first_q <= first_n;
      oen_q   <= oen_n;
      rxd_q   <= rxd_n;
      rxv_q   <= rxv_n;
      rxf_q   <= rxf_n;
      busy_q  <= busy_n;
      start_q <= start_n;
      stop_q  <= stop_n;
    end
  end

  // full_q marks that 8 bits have been clocked in, so the next SCL fall is the
  // start of the ACK slot. It also hides the SCL fall that follows a START.
  // tx_rd is a Mealy strobe so tx_data is sampled in the same cycle it is
  // requested and the first bit is on SDA the cycle after the SCL fall.
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    shift_n = shift_q;
    full_n  = full_q;
    first_n = first_q;
    oen_n   = oen_q;
    rxd_n   = rxd_q;
    rxv_n   = 1'b0;
    rxf_n   = 1'b0;
    busy_n  = busy_q;
    start_n = 1'b0;
    stop_n  = 1'b0;
    tx_rd_c = 1'b0;

    case (state)
      IDLE, WAIT_STOP: oen_n = 1'b1;
      ADDR: begin
        if (scl_r) begin
          shift_n = {shift_q[6:0], sda_s};
          cnt_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) full_n = 1'b1;
        end else if (scl_f && full_q) begin
          full_n = 1'b0;
          if (shift_q[7:1] == ADDRESS) begin
            oen_n   = 1'b0;
            state_n = ADDR_ACK;
          end else begin
            state_n = WAIT_STOP;
          end
        end
      end
      ADDR_ACK: begin
        if (scl_f) begin
          cnt_n = '0;
          if (!shift_q[0]) begin
            oen_n   = 1'b1;
            state_n = WR_BYTE;
          end else begin
            tx_rd_c = 1'b1;
            shift_n = bus.tx_data;
            oen_n   = bus.tx_data[7];
            state_n = RD_BYTE;
          end
        end
      end
      WR_BYTE: begin
        if (scl_r) begin
          shift_n = {shift_q[6:0], sda_s};
          cnt_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            full_n  = 1'b1;
            rxd_n   = {shift_q[6:0], sda_s};
            rxv_n   = 1'b1;
            rxf_n   = first_q;
            first_n = 1'b0;
          end
        end else if (scl_f && full_q) begin
          full_n  = 1'b0;
          oen_n   = 1'b0;
          state_n = WR_ACK;
        end
      end
      WR_ACK: begin
        if (scl_f) begin
          oen_n   = 1'b1;
          state_n = WR_BYTE;
        end
      end
      RD_BYTE: begin
        if (scl_f) begin
          if (bit_cnt == 3'd7) begin
            cnt_n   = '0;
            oen_n   = 1'b1;
            state_n = RD_ACK;
          end else begin
            cnt_n   = bit_cnt + 3'd1;
            shift_n = {shift_q[6:0], 1'b0};
            oen_n   = shift_q[6];
          end
        end
      end
      RD_ACK: begin
        if (scl_r && sda_s) begin
          state_n = WAIT_STOP;
        end else if (scl_f) begin
          tx_rd_c = 1'b1;
          shift_n = bus.tx_data;
          oen_n   = bus.tx_data[7];
          cnt_n   = '0;
          state_n = RD_BYTE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start_ev) begin
      state_n = ADDR;
      cnt_n   = '0;
      full_n  = 1'b0;
      first_n = 1'b1;
      oen_n   = 1'b1;
      busy_n  = 1'b1;
      start_n = 1'b1;
      tx_rd_c = 1'b0;
      rxv_n   = 1'b0;
      rxf_n   = 1'b0;
    end else if (stop_ev) begin
      state_n = IDLE;
      oen_n   = 1'b1;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
      tx_rd_c = 1'b0;
      rxv_n   = 1'b0;
      rxf_n   = 1'b0;
    end
  end

  assign bus.sda_o     = 1'b0;
  assign bus.sda_oen   = oen_q;
  assign bus.rx_data   = rxd_q;
  assign bus.rx_valid  = rxv_q;
  assign bus.rx_first  = rxf_q;
  assign bus.tx_rd     = tx_rd_c;
  assign bus.busy      = busy_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_slave_engine.sv
// tb_i2c_slave_engine
// Directed bench for i2c_slave_engine: bit-banged I2C master with a wired-AND
// SDA model, a strobe monitor, and one task per scenario.
module tb_i2c_slave_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_val = 8'h00;
  int         total = 0;
  int         bad = 0;

  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         st_cnt = 0;
  int         sp_cnt = 0;
  logic [8:0] rx_log[$];

  i2c_slave_engine_if bus();

  assign bus.scl_i   = scl_m;
  assign bus.sda_i   = sda_m & (bus.sda_oen | bus.sda_o);
  assign bus.tx_data = tx_val;

  i2c_slave_engine #(.ADDRESS(7'h0F), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_cnt++;
      rx_log.push_back({bus.rx_first, bus.rx_data});
    end
    if (bus.tx_rd)     tx_cnt++;
    if (bus.start_det) st_cnt++;
    if (bus.stop_det)  sp_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    tick(5);
    sda_m = b;
    tick(5);
    scl_m = 1'b1;
    tick(5);
    s = bus.sda_i;
    tick(5);
    scl_m = 1'b0;
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    tick(10);
    scl_m = 1'b1;
    tick(10);
    sda_m = 1'b0;
    tick(10);
    scl_m = 1'b0;
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    tick(10);
    scl_m = 1'b1;
    tick(10);
    sda_m = 1'b1;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(ack_bit, s);
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (bus.sda_oen !== 1'b1) begin bad++; $display("[TB] FAIL rst_sda_oen got=%b want=1", bus.sda_oen); end
    total++; if (bus.sda_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_sda_o got=%b want=0", bus.sda_o); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_rx_data got=%h want=00", bus.rx_data); end
    total++; if ({bus.rx_valid, bus.tx_rd, bus.start_det, bus.stop_det} !== 4'b0000) begin
      bad++; $display("[TB] FAIL rst_strobes got=%b want=0000", {bus.rx_valid, bus.tx_rd, bus.start_det, bus.stop_det});
    end
    rst_n = 1'b1;
    tick(10);
    total++; if (st_cnt + sp_cnt !== 0) begin bad++; $display("[TB] FAIL rst_no_events got=%0d want=0", st_cnt + sp_cnt); end
  endtask

  task automatic test_write();
    logic ack;
    int rx0 = rx_cnt;
    int sp0 = sp_cnt;
    do_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy_high got=%b want=1", bus.busy); end
    send_byte(8'h1E, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_addr_ack got=%b want=0", ack); end
    send_byte(8'hA5, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_d0_ack got=%b want=0", ack); end
    send_byte(8'h3C, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL wr_d1_ack got=%b want=0", ack); end
    do_stop();
    total++; if (rx_cnt - rx0 !== 2) begin bad++; $display("[TB] FAIL wr_rx_count got=%0d want=2", rx_cnt - rx0); end
    if (rx_cnt - rx0 >= 2) begin
      total++; if (rx_log[rx0] !== {1'b1, 8'hA5}) begin bad++; $display("[TB] FAIL wr_rx0 got=%h want=1a5", rx_log[rx0]); end
      total++; if (rx_log[rx0+1] !== {1'b0, 8'h3C}) begin bad++; $display("[TB] FAIL wr_rx1 got=%h want=03c", rx_log[rx0+1]); end
    end
    total++; if (bus.rx_data !== 8'h3C) begin bad++; $display("[TB] FAIL wr_rx_data_hold got=%h want=3c", bus.rx_data); end
    total++; if (sp_cnt - sp0 !== 1) begin bad++; $display("[TB] FAIL wr_stop_count got=%0d want=1", sp_cnt - sp0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_busy_low got=%b want=0", bus.busy); end
  endtask

  task automatic test_nack_addr();
    logic ack;
    int rx0 = rx_cnt;
    do_start();
    send_byte(8'h20, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("[TB] FAIL nack_addr got=%b want=1", ack); end
    send_byte(8'h55, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("[TB] FAIL nack_data got=%b want=1", ack); end
    total++; if (bus.sda_oen !== 1'b1) begin bad++; $display("[TB] FAIL nack_released got=%b want=1", bus.sda_oen); end
    do_stop();
    total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("[TB] FAIL nack_rx_count got=%0d want=0", rx_cnt - rx0); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    int tx0 = tx_cnt;
    tx_val = 8'h81;
    do_start();
    send_byte(8'h1F, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rd_addr_ack got=%b want=0", ack); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h81) begin bad++; $display("[TB] FAIL rd_byte0 got=%h want=81", d); end
    tx_val = 8'h7E;
    read_byte(1'b1, d);
    total++; if (d !== 8'h7E) begin bad++; $display("[TB] FAIL rd_byte1 got=%h want=7e", d); end
    tick(6);
    total++; if (bus.sda_oen !== 1'b1) begin bad++; $display("[TB] FAIL rd_release got=%b want=1", bus.sda_oen); end
    do_stop();
    total++; if (tx_cnt - tx0 !== 2) begin bad++; $display("[TB] FAIL rd_tx_count got=%0d want=2", tx_cnt - tx0); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    int rx0 = rx_cnt;
    int tx0 = tx_cnt;
    int st0 = st_cnt;
    do_start();
    send_byte(8'h1E, ack);
    send_byte(8'h05, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rs_wr_ack got=%b want=0", ack); end
    tx_val = 8'hC3;
    do_start();
    send_byte(8'h1F, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL rs_rd_addr_ack got=%b want=0", ack); end
    read_byte(1'b1, d);
    total++; if (d !== 8'hC3) begin bad++; $display("[TB] FAIL rs_rd_byte got=%h want=c3", d); end
    do_stop();
    total++; if (st_cnt - st0 !== 2) begin bad++; $display("[TB] FAIL rs_start_count got=%0d want=2", st_cnt - st0); end
    total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("[TB] FAIL rs_rx_count got=%0d want=1", rx_cnt - rx0); end
    if (rx_cnt - rx0 >= 1) begin
      total++; if (rx_log[rx0] !== {1'b1, 8'h05}) begin bad++; $display("[TB] FAIL rs_rx0 got=%h want=105", rx_log[rx0]); end
    end
    total++; if (tx_cnt - tx0 !== 1) begin bad++; $display("[TB] FAIL rs_tx_count got=%0d want=1", tx_cnt - tx0); end
  endtask

  task automatic test_glitch();
    int st0 = st_cnt;
    int exp_st;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    exp_st = 0;
`else
    exp_st = 1;
`endif
    tick(5);
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    tick(20);
    total++; if (st_cnt - st0 !== exp_st) begin bad++; $display("[TB] FAIL glitch_start got=%0d want=%0d", st_cnt - st0, exp_st); end
    total++; if (bus.sda_oen !== 1'b1) begin bad++; $display("[TB] FAIL glitch_sda got=%b want=1", bus.sda_oen); end
  endtask

  task automatic test_reset_mid_read();
    logic ack, s;
    int ev0, st0;
    tx_val = 8'h81;
    do_start();
    send_byte(8'h1F, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
    tick(6);
    total++; if (bus.sda_oen !== 1'b0) begin bad++; $display("[TB] FAIL mr_drive_low got=%b want=0", bus.sda_oen); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.sda_oen !== 1'b1) begin bad++; $display("[TB] FAIL mr_async_release got=%b want=1", bus.sda_oen); end
    tick(1);
    rst_n = 1'b1;
    ev0 = rx_cnt + tx_cnt + st_cnt + sp_cnt;
    for (int i = 0; i < 5; i++) clock_bit(1'b1, s);
    total++; if (rx_cnt + tx_cnt + st_cnt + sp_cnt - ev0 !== 0) begin
      bad++; $display("[TB] FAIL mr_no_strobes got=%0d want=0", rx_cnt + tx_cnt + st_cnt + sp_cnt - ev0);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mr_busy got=%b want=0", bus.busy); end
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("[TB] FAIL mr_rx_data got=%h want=00", bus.rx_data); end
    st0 = st_cnt;
    do_start();
    total++; if (st_cnt - st0 !== 1) begin bad++; $display("[TB] FAIL mr_next_start got=%0d want=1", st_cnt - st0); end
    send_byte(8'h1E, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("[TB] FAIL mr_addr_ack got=%b want=0", ack); end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_nack_addr();
    test_read();
    test_repeated_start();
    test_glitch();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_engine.md
Name: i2c_slave_engine

Overview:
- Byte-level I2C responder (target) for the monitor's I2C pad infrastructure.
- Consumes the synchronous-domain pad signals sda_i and scl_i, and drives sda_o/sda_oen back to the SDA bidirectional buffer.
- SCL is input-only; no clock stretching.
- Detects START/STOP, matches a 7-bit address, ACKs, delivers written bytes to the register layer, and fetches read bytes from it.

Parameters:
- ADDRESS, 7'h0F, 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2, flip-flop stages on scl_i and sda_i before edge detection (min 2).

Ports:
- clk  input  1  system clock, at least 10x the SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  SCL from pad.
- sda_i  input  1  SDA from pad.
- sda_o  output  1  SDA drive value; constant 0 (open-drain emulation).
- sda_oen  output  1  SDA output enable, active low; 0 pulls SDA low, 1 releases.
- rx_data  output  8  last byte written by the master; valid while rx_valid=1.
- rx_valid  output  1  one-cycle strobe per written data byte (address byte excluded).
- rx_first  output  1  qualifies rx_valid: first data byte after the address (register pointer).
- tx_data  input  8  read byte; sampled in the cycle tx_rd=1.
- tx_rd  output  1  one-cycle strobe requesting and consuming the next read byte.
- busy  output  1  high from START to STOP.
- start_det  output  1  one-cycle strobe on START or repeated START.
- stop_det  output  1  one-cycle strobe on STOP.

Behaviour:
- Reset values: sda_oen=1, sda_o=0, all strobes=0, busy=0, rx_data=0, state=IDLE, synchroniser flops=1.
- Synchronisation and events (on synchronised signals only):
  - scl_r: SCL rising edge. scl_f: SCL falling edge.
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - Event latency from pin change is SYNC_STAGES+1 clk.
- Shifting rules:
  - Bits are sampled on scl_r, MSB first.
  - sda_oen changes only on scl_f, and becomes valid in the cycle after the scl_f detect.
  - A 3-bit counter counts bits 0..7; the 9th clock is the ACK slot.
- States:
  - IDLE: sda_oen=1. START -> ADDR.
  - ADDR: shift 8 bits. On the 8th scl_f:
    - if addr[7:1]==ADDRESS, drive ACK (sda_oen=0) and go to ADDR_ACK;
    - otherwise go to WAIT_STOP with sda released.
  - ADDR_ACK: on the next scl_f, release SDA.
    - R/W=0 -> WR_BYTE.
    - R/W=1 -> pulse tx_rd, load tx_data into the shift register, drive bit7 (sda_oen=bit7), go to RD_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th scl_r, set rx_data and pulse rx_valid (rx_first=1 only for the first byte of this transfer). On the 8th scl_f, drive ACK -> WR_ACK.
  - WR_ACK: on scl_f, release -> WR_BYTE.
  - RD_BYTE: on each scl_f, present the next bit. After the 8th bit's scl_f, release -> RD_ACK.
  - RD_ACK: sample SDA on scl_r.
    - SDA=0 (ACK): on scl_f pulse tx_rd, load tx_data, drive bit7 -> RD_BYTE.
    - SDA=1 (NACK): go to WAIT_STOP, sda released.
  - WAIT_STOP: sda_oen=1. Ignore traffic until START or STOP.
- Overrides, applied in any state:
  - START -> ADDR, bit counter cleared, sda released, rx_first re-armed.
  - STOP -> IDLE, sda released.
  - START/STOP take priority over a coincident scl edge.
- busy: set on START, cleared on STOP.
- rst_n asserted mid-transfer releases SDA immediately (asynchronously) and returns to IDLE. Following reset release, the engine ignores the bus until the next START.
- Ten-bit and general-call addresses are not supported; both are NACKed.

Optional Feature:
- Macro I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter follows the synchronisers on both SCL and SDA. This rejects pulses of 1 clk or shorter, and event latency grows by 2 clk.
- Undefined: no filter; latency stays SYNC_STAGES+1.

Test Plan:
- Write 0x1E (addr 0x0F, W), 0xA5, 0x3C, STOP -> ACKs on all three bytes; rx_valid twice with 0xA5 (rx_first=1) then 0x3C (rx_first=0); stop_det once; busy low after STOP.
- Address 0x10 write -> SDA released on ACK slot (NACK); no rx_valid; following bytes ignored until STOP.
- Read 0x1F, tx_data=0x81 then 0x7E, master ACK then NACK -> SDA bits observed 10000001 then 01111110; tx_rd pulses exactly twice; SDA released after the NACK.
- Write 0x1E, 0x05, repeated START, 0x1F, read 1 byte, NACK, STOP -> start_det twice; rx_valid once (0x05, rx_first=1); tx_rd once.
- rst_n pulsed low during the 5th bit of a read driving 0 -> sda_oen=1 within the reset cycle; no strobes after release until the next START.
- With I2C_SLAVE_GLITCH_FILTER_EN, a 1-clk low glitch on SDA while SCL high -> no start_det; without the macro -> start_det pulses.
